// File: rtl/awb_gain_if.sv
// Request/result bundle for the gray-world AWB gain calculator.
// The producer side (statistics block) is master; the calculator is slave.
interface awb_gain_if;
  logic        valid_i;
  logic [7:0]  r_mean_i;
  logic [7:0]  g_mean_i;
  logic [7:0]  b_mean_i;
  logic [15:0] K_R_o;
  logic [15:0] K_G_o;
  logic [15:0] K_B_o;
  logic        finish_o;

  modport master (
    output valid_i, r_mean_i, g_mean_i, b_mean_i,
    input  K_R_o, K_G_o, K_B_o, finish_o
  );

  modport slave (
    input  valid_i, r_mean_i, g_mean_i, b_mean_i,
    output K_R_o, K_G_o, K_B_o, finish_o
  );
endinterface

// File: rtl/awb_gain.sv
// Gray-world AWB gains: K_c = floor(((r+g+b)<<8) / (3*mean_c)) in Q8.8,
// computed with one shared 18-step restoring divider, channels R, G, B in turn.
module awb_gain (
  input  logic        clk,
  input  logic        rst_n,
  awb_gain_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    DIV_R,
    DIV_G,
    DIV_B,
    DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [17:0] num;
  logic [9:0]  div_r;
  logic [9:0]  div_g;
  logic [9:0]  div_b;
  logic [4:0]  cnt;
  logic [10:0] rem;
  logic [17:0] quo;
  logic [15:0] hold_r;
  logic [15:0] hold_g;
  logic [15:0] k_r;
  logic [15:0] k_g;
  logic [15:0] k_b;
  logic        finish;

  logic [9:0]  divisor;
  logic [4:0]  bit_idx;
  logic [10:0] trial;
  logic        fits;
  logic [10:0] rem_next;
  logic [17:0] quo_next;
  logic [15:0] gain_next;
  logic        last_step;
  logic [9:0]  sum;

  assign sum       = 10'(bus.r_mean_i) + 10'(bus.g_mean_i) + 10'(bus.b_mean_i);
  assign last_step = (cnt == 5'd17);
  assign bit_idx   = 5'd17 - cnt;

  // One restoring step; rem[10] stands for the bit shifted out of the
  // 11-bit window, which forces a subtract when set.
  always_comb begin
    divisor = div_r;
    case (state)
      DIV_G:   divisor = div_g;
      DIV_B:   divisor = div_b;
      default: divisor = div_r;
    endcase
    trial     = {rem[9:0], num[bit_idx]};
    fits      = rem[10] | (trial >= {1'b0, divisor});
    rem_next  = fits ? (trial - {1'b0, divisor}) : trial;
    quo_next  = quo | (18'(fits) << bit_idx);
    gain_next = ((divisor == '0) || (|quo_next[17:16])) ? 16'hFFFF : quo_next[15:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.valid_i) state_next = DIV_R;
      DIV_R:   if (last_step)   state_next = DIV_G;
      DIV_G:   if (last_step)   state_next = DIV_B;
      DIV_B:   if (last_step)   state_next = DONE;
      DONE:                     state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num    <= '0;
      div_r  <= '0;
      div_g  <= '0;
      div_b  <= '0;
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      hold_r <= '0;
      hold_g <= '0;
      k_r    <= '0;
      k_g    <= '0;
      k_b    <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            num   <= {sum, 8'h00};
            div_r <= 10'(bus.r_mean_i) * 10'd3;
            div_g <= 10'(bus.g_mean_i) * 10'd3;
            div_b <= 10'(bus.b_mean_i) * 10'd3;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
          end
        end
        DIV_R, DIV_G, DIV_B: begin
          if (last_step) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            if (state == DIV_R) hold_r <= gain_next;
            if (state == DIV_G) hold_g <= gain_next;
            if (state == DIV_B) begin
              k_r    <= hold_r;
              k_g    <= hold_g;
              k_b    <= gain_next;
              finish <= 1'b1;
            end
          end else begin
            cnt <= cnt + 5'd1;
            rem <= rem_next;
            quo <= quo_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.K_R_o    = k_r;
  assign bus.K_G_o    = k_g;
  assign bus.K_B_o    = k_b;
  assign bus.finish_o = finish;

endmodule

// File: tb/tb_awb_gain.sv
// Randomized self-checking bench for awb_gain against a plain-arithmetic
// gray-world model (latency, pulse width, hold behaviour, reset abort).
module tb_awb_gain;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  awb_gain_if bus ();

  awb_gain dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_r   = 0;
  int unsigned exp_g   = 0;
  int unsigned exp_b   = 0;

  function automatic int unsigned ref_gain(int unsigned r, int unsigned g,
                                           int unsigned b, int unsigned m);
    if (m == 0) return 32'hFFFF;
    return ((r + g + b) * 256) / (3 * m);
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic expect_gains(input string tag, input int unsigned r,
                              input int unsigned g, input int unsigned b);
    exp_r = ref_gain(r, g, b, r);
    exp_g = ref_gain(r, g, b, g);
    exp_b = ref_gain(r, g, b, b);
    check({tag, "_kr"}, bus.K_R_o, exp_r);
    check({tag, "_kg"}, bus.K_G_o, exp_g);
    check({tag, "_kb"}, bus.K_B_o, exp_b);
  endtask

  // Called #1 after the capture edge; counts edges up to finish_o and
  // verifies the previous result is held unchanged meanwhile.
  task automatic wait_finish(input string tag);
    int unsigned n = 0;
    bit held = 1'b1;
    while (!bus.finish_o && n < 70) begin
      if (bus.K_R_o !== exp_r || bus.K_G_o !== exp_g || bus.K_B_o !== exp_b) held = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 54);
    check({tag, "_hold"}, held, 1);
  endtask

  task automatic request(input string tag, input int unsigned r,
                         input int unsigned g, input int unsigned b);
    @(negedge clk);
    bus.r_mean_i = 8'(r);
    bus.g_mean_i = 8'(g);
    bus.b_mean_i = 8'(b);
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i  = 1'b0;
    bus.r_mean_i = 8'($urandom);
    bus.g_mean_i = 8'($urandom);
    bus.b_mean_i = 8'($urandom);
    wait_finish(tag);
    expect_gains(tag, r, g, b);
    @(posedge clk); #1;
    check({tag, "_pulse"}, bus.finish_o, 0);
  endtask

  initial begin
    int unsigned n;
    int unsigned pulses;
    int unsigned rr, gg, bb;

    rst_n        = 1'b0;
    bus.valid_i  = 1'b1;
    bus.r_mean_i = 8'd50;
    bus.g_mean_i = 8'd100;
    bus.b_mean_i = 8'd50;
    #12;
    check("rst_kr", bus.K_R_o, 0);
    check("rst_kg", bus.K_G_o, 0);
    check("rst_kb", bus.K_B_o, 0);
    check("rst_finish", bus.finish_o, 0);

    // valid already high at release: first edge is the capture edge
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    wait_finish("tp1");
    expect_gains("tp1", 50, 100, 50);
    check("tp1_lit_kr", bus.K_R_o, 341);
    check("tp1_lit_kg", bus.K_G_o, 170);
    @(posedge clk); #1;
    check("tp1_pulse", bus.finish_o, 0);

    request("eq128", 128, 128, 128);
    check("eq128_lit", bus.K_G_o, 256);
    request("eq255", 255, 255, 255);
    request("zero_r", 0, 90, 30);
    check("zero_r_lit", bus.K_R_o, 32'hFFFF);
    request("tiny_r", 1, 255, 255);
    check("tiny_r_lit", bus.K_R_o, 43605);

    // continuous valid; inputs change mid-computation
    @(negedge clk);
    bus.r_mean_i = 8'd50;
    bus.g_mean_i = 8'd100;
    bus.b_mean_i = 8'd50;
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.finish_o && n < 70) begin
      @(posedge clk); #1;
      n++;
      if (n == 20) begin
        bus.r_mean_i = 8'd100;
        bus.g_mean_i = 8'd100;
        bus.b_mean_i = 8'd50;
      end
    end
    check("cont_latency", n, 54);
    expect_gains("cont1", 50, 100, 50);
    n = 0;
    pulses = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check("cont_width", bus.finish_o, 0);
    end while (!bus.finish_o && n < 70);
    bus.valid_i = 1'b0;
    check("cont_period", n, 56);
    expect_gains("cont2", 100, 100, 50);
    check("cont2_lit_kb", bus.K_B_o, 426);
    @(posedge clk); #1;
    check("cont2_pulse", bus.finish_o, 0);

    for (int i = 0; i < 10; i++) begin
      rr = $urandom_range(255, 0);
      gg = $urandom_range(255, 0);
      bb = $urandom_range(255, 0);
      case ($urandom_range(7, 0))
        0: rr = 0;
        1: gg = 0;
        2: bb = 0;
        default: ;
      endcase
      request($sformatf("rand%0d", i), rr, gg, bb);
    end

    // reset mid-computation
    @(negedge clk);
    bus.r_mean_i = 8'd50;
    bus.g_mean_i = 8'd100;
    bus.b_mean_i = 8'd50;
    bus.valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_kr", bus.K_R_o, 0);
    check("abort_kb", bus.K_B_o, 0);
    check("abort_finish", bus.finish_o, 0);
    exp_r = 0;
    exp_g = 0;
    exp_b = 0;
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (bus.finish_o) pulses++;
    end
    check("abort_no_pulse", pulses, 0);
    request("post_abort", 200, 10, 90);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
